// File: rtl/cacheline_burst_adapter_if.sv
// ============================================================================
// Module  : cacheline_burst_adapter_if
// Brief   : Cache-line request port and memory burst port of the line adapter.
//           ADAPTER_STROBE_EN adds the line_byte_enable signal.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cacheline_burst_adapter_if #(
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int BURST_LEN        = 4
);
    localparam int BW = CACHE_LINE_WIDTH / BURST_LEN;

    logic [31:0]                 line_address;
    logic                        line_read;
    logic                        line_write;
    logic [CACHE_LINE_WIDTH-1:0] line_wdata;
    logic [CACHE_LINE_WIDTH-1:0] line_rdata;
    logic                        line_resp;
`ifdef ADAPTER_STROBE_EN
    logic [CACHE_LINE_WIDTH/8-1:0] line_byte_enable;
`endif
    logic [31:0]                 mem_address;
    logic                        mem_read;
    logic                        mem_write;
    logic [BW-1:0]               mem_wdata;
    logic [BW/8-1:0]             mem_byte_enable;
    logic [BW-1:0]               mem_rdata;
    logic                        mem_resp;
    logic                        pm_error;

    modport slave (
`ifdef ADAPTER_STROBE_EN
        input  line_byte_enable,
`endif
        input  line_address, line_read, line_write, line_wdata,
        input  mem_rdata, mem_resp,
        output line_rdata, line_resp,
        output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        output pm_error
    );

    modport master (
`ifdef ADAPTER_STROBE_EN
        output line_byte_enable,
`endif
        output line_address, line_read, line_write, line_wdata,
        output mem_rdata, mem_resp,
        input  line_rdata, line_resp,
        input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        input  pm_error
    );
endinterface

`default_nettype wire

// File: rtl/cacheline_burst_adapter.sv
// ============================================================================
// Module  : cacheline_burst_adapter
// Brief   : Turns single-cycle cache-line requests into multi-beat memory
//           bursts. Optional per-byte write strobes via ADAPTER_STROBE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_burst_adapter #(
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int BURST_LEN        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    cacheline_burst_adapter_if.slave bus
);
    localparam int c_BW  = CACHE_LINE_WIDTH / BURST_LEN;
    localparam int c_BEW = c_BW / 8;
    localparam int c_OFF = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int c_CW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [c_CW-1:0]             r_beat;
    logic [31:0]                 r_addr;
    logic [CACHE_LINE_WIDTH-1:0] r_wline;
    logic [CACHE_LINE_WIDTH-1:0] r_rbuf;
    logic [CACHE_LINE_WIDTH-1:0] r_rline;
    logic [CACHE_LINE_WIDTH-1:0] w_rbuf_nxt;
    logic                        r_pm_error;

    logic w_accept_rd;
    logic w_accept_wr;
    logic w_beat_en;
    logic w_last;
    logic w_mem_read;
    logic w_mem_write;
    logic w_unused_addr_bits;

    assign w_unused_addr_bits = ^bus.line_address[c_OFF-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept_rd = 1'b0;
        w_accept_wr = 1'b0;
        w_beat_en   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.line_write) begin
                    w_accept_wr = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else if (bus.line_read) begin
                    w_accept_rd = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (bus.mem_resp) begin
                    w_beat_en = 1'b1;
                    if (r_beat == c_LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rbuf_nxt = r_rbuf;
        w_rbuf_nxt[r_beat*c_BW +: c_BW] = bus.mem_rdata;
    end

    // Reads assemble in r_rbuf so line_rdata keeps the previous line until
    // the next read has fully arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat     <= '0;
            r_addr     <= '0;
            r_wline    <= '0;
            r_rbuf     <= '0;
            r_rline    <= '0;
            r_pm_error <= 1'b0;
        end else begin
            if (w_accept_rd || w_accept_wr) begin
                r_addr <= {bus.line_address[31:c_OFF], {c_OFF{1'b0}}};
                r_beat <= '0;
            end
            if (w_accept_wr) r_wline <= bus.line_wdata;
            if (w_beat_en && !w_last) r_beat <= r_beat + 1'b1;
            if (w_beat_en && (r_state == ST_READ)) begin
                r_rbuf <= w_rbuf_nxt;
                if (w_last) r_rline <= w_rbuf_nxt;
            end
            if ((bus.mem_resp && ((r_state == ST_IDLE) || (r_state == ST_DONE))) ||
                (w_mem_read && w_mem_write))
                r_pm_error <= 1'b1;
        end
    end

    assign w_mem_read  = (r_state == ST_READ);
    assign w_mem_write = (r_state == ST_WRITE);

    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.mem_address = r_addr;
    assign bus.mem_wdata   = r_wline[r_beat*c_BW +: c_BW];
    assign bus.line_rdata  = r_rline;
    assign bus.line_resp   = (r_state == ST_DONE);
    assign bus.pm_error    = r_pm_error;

`ifdef ADAPTER_STROBE_EN
    logic [CACHE_LINE_WIDTH/8-1:0] r_strb;

    always_ff @(posedge clk) begin
        if (rst)              r_strb <= '0;
        else if (w_accept_wr) r_strb <= bus.line_byte_enable;
    end

    assign bus.mem_byte_enable = w_mem_write ? r_strb[r_beat*c_BEW +: c_BEW] : '1;
`else
    assign bus.mem_byte_enable = '1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cacheline_burst_adapter.sv
// ============================================================================
// Module  : tb_cacheline_burst_adapter
// Brief   : Directed self-checking bench for cacheline_burst_adapter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cacheline_burst_adapter;
    localparam int c_CLW = 256;
    localparam int c_BL  = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cacheline_burst_adapter_if #(.CACHE_LINE_WIDTH(c_CLW), .BURST_LEN(c_BL)) bus ();

    cacheline_burst_adapter #(.CACHE_LINE_WIDTH(c_CLW), .BURST_LEN(c_BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0]  rb [4];
    logic [63:0]  rb2 [4];
    logic [63:0]  mem_store [4];
    logic [255:0] wl;
    logic [7:0]   be_exp;
    logic         resp;
    int           b;

    initial begin
        rb[0]  = 64'h1111_1111_1111_1111;
        rb[1]  = 64'h2222_2222_2222_2222;
        rb[2]  = 64'h3333_3333_3333_3333;
        rb[3]  = 64'h4444_4444_4444_4444;
        rb2[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        rb2[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        rb2[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        rb2[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        wl = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
              64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};

        rst              = 1'b1;
        bus.line_address = '0;
        bus.line_read    = 1'b0;
        bus.line_write   = 1'b0;
        bus.line_wdata   = '0;
        bus.mem_rdata    = '0;
        bus.mem_resp     = 1'b0;
`ifdef ADAPTER_STROBE_EN
        bus.line_byte_enable = '0;
`endif
        tick();
        tick();

        // reset values
        chk("rst_mem_read",  bus.mem_read, 1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_line_resp", bus.line_resp, 1'b0);
        chk("rst_pm_error",  bus.pm_error, 1'b0);
        chk("rst_mem_addr",  bus.mem_address, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'h0);
        chk("rst_line_rdata", bus.line_rdata, 256'h0);
        chk("rst_byte_en",   bus.mem_byte_enable, 8'hFF);
        rst = 1'b0;
        tick();

        // read of 0x1234, first beat 13 edges after acceptance
        bus.line_address = 32'h0000_1234;
        bus.line_read    = 1'b1;
        tick();
        bus.line_read    = 1'b0;
        bus.line_address = 32'hFFFF_FFFF;
        chk("rd_cmd",  bus.mem_read, 1'b1);
        chk("rd_addr", bus.mem_address, 32'h0000_1220);
        for (int k = 1; k <= 16; k++) begin
            bus.mem_resp  = (k >= 13);
            bus.mem_rdata = (k >= 13) ? rb[k-13] : 64'h0;
            tick();
            if (k == 12) chk("rd_addr_hold", bus.mem_address, 32'h0000_1220);
            if (k == 15) begin
                chk("rd_cmd_hold",   bus.mem_read, 1'b1);
                chk("rd_resp_early", bus.line_resp, 1'b0);
            end
        end
        chk("rd_resp",      bus.line_resp, 1'b1);
        chk("rd_cmd_drop",  bus.mem_read, 1'b0);
        chk("rd_line",      bus.line_rdata, {rb[3], rb[2], rb[1], rb[0]});
        bus.mem_resp = 1'b0;
        tick();
        chk("rd_resp_pulse", bus.line_resp, 1'b0);
        chk("rd_line_hold",  bus.line_rdata, {rb[3], rb[2], rb[1], rb[0]});

        // write with read also requested, gapped beats at edges 2,3,5,8
        bus.line_address = 32'h0000_401F;
        bus.line_write   = 1'b1;
        bus.line_read    = 1'b1;
        bus.line_wdata   = wl;
`ifdef ADAPTER_STROBE_EN
        bus.line_byte_enable = 32'h0000_00F0;
`endif
        tick();
        bus.line_wdata = '0;
`ifdef ADAPTER_STROBE_EN
        bus.line_byte_enable = '1;
`endif
        chk("wr_cmd",  bus.mem_write, 1'b1);
        chk("wr_addr", bus.mem_address, 32'h0000_4000);
        b = 0;
        for (int k = 1; k <= 8; k++) begin
            chk("wr_no_read", bus.mem_read, 1'b0);
            chk("wr_beat_data", bus.mem_wdata, {32'hDEAD_BEEF, 32'(b)});
`ifdef ADAPTER_STROBE_EN
            be_exp = (b == 0) ? 8'hF0 : 8'h00;
`else
            be_exp = 8'hFF;
`endif
            chk("wr_byte_en", bus.mem_byte_enable, be_exp);
            resp = (k == 2) || (k == 3) || (k == 5) || (k == 8);
            if (resp) begin
                mem_store[b] = bus.mem_wdata;
                b++;
            end
            bus.mem_resp = resp;
            tick();
        end
        bus.mem_resp = 1'b0;
        chk("wr_resp",     bus.line_resp, 1'b1);
        chk("wr_cmd_drop", bus.mem_write, 1'b0);
        tick();
        chk("wr_resp_pulse", bus.line_resp, 1'b0);
        bus.line_write = 1'b0;
        bus.line_read  = 1'b0;
        tick();
        chk("wr_no_reaccept_w", bus.mem_write, 1'b0);
        chk("wr_no_reaccept_r", bus.mem_read, 1'b0);
        for (int i = 0; i < 4; i++)
            chk("wr_mem_contents", mem_store[i], wl[i*64 +: 64]);
        chk("wr_no_pm_error", bus.pm_error, 1'b0);
        chk("wr_byte_en_idle", bus.mem_byte_enable, 8'hFF);

        // reset after three beats of a read
        bus.line_address = 32'h0000_0080;
        bus.line_read    = 1'b1;
        tick();
        bus.line_read = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = rb2[k-1];
            tick();
        end
        chk("rst_mid_busy", bus.mem_read, 1'b1);
        bus.mem_resp = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_mid_read_drop", bus.mem_read, 1'b0);
        chk("rst_mid_no_resp",   bus.line_resp, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_mid_no_resp2",  bus.line_resp, 1'b0);

        // read following the aborted one completes normally
        bus.line_address = 32'h0000_0100;
        bus.line_read    = 1'b1;
        tick();
        bus.line_read = 1'b0;
        chk("rd2_addr", bus.mem_address, 32'h0000_0100);
        for (int k = 1; k <= 4; k++) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = rb2[k-1];
            tick();
            if (k == 3) chk("rd2_resp_early", bus.line_resp, 1'b0);
        end
        bus.mem_resp = 1'b0;
        chk("rd2_resp", bus.line_resp, 1'b1);
        chk("rd2_line", bus.line_rdata, {rb2[3], rb2[2], rb2[1], rb2[0]});
        tick();

        // spurious beat in IDLE
        chk("pm_clear", bus.pm_error, 1'b0);
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        chk("pm_set", bus.pm_error, 1'b1);
        tick();
        tick();
        chk("pm_sticky", bus.pm_error, 1'b1);
        chk("pm_no_cmd", bus.mem_read, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("pm_rst_clear", bus.pm_error, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
